// File: rtl/vx_mem_arb_pkg.sv
// Shared types and default widths for the Vortex memory arbiter.
package vx_mem_arb_pkg;

    localparam int unsigned DEF_NUM_REQS   = 2;
    localparam int unsigned DEF_DATA_WIDTH = 512;
    localparam int unsigned DEF_ADDR_WIDTH = 26;
    localparam int unsigned DEF_TAG_WIDTH  = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/vx_rr_picker.sv
// Combinational picker: first valid requester at or after i_ptr, wrapping modulo NUM_REQS.
module vx_rr_picker
    import vx_mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQS  = DEF_NUM_REQS,
    parameter int unsigned IDX_WIDTH = 1
) (
    input  logic [NUM_REQS-1:0]  i_valid,
    input  logic [IDX_WIDTH-1:0] i_ptr,
    output logic [IDX_WIDTH-1:0] o_idx_c,
    output logic                 o_any_c
);

    int unsigned w_pos;

    // Walk offsets from farthest to nearest so the closest valid to i_ptr wins.
    always_comb begin
        o_idx_c = '0;
        o_any_c = |i_valid;
        w_pos   = 0;
        for (int unsigned k = 0; k < NUM_REQS; k++) begin
            w_pos = 32'(i_ptr) + (NUM_REQS - 1 - k);
            if (w_pos >= NUM_REQS) begin
                w_pos = w_pos - NUM_REQS;
            end
            if (i_valid[IDX_WIDTH'(w_pos)]) begin
                o_idx_c = IDX_WIDTH'(w_pos);
            end
        end
    end

endmodule

// File: rtl/vx_mem_arbiter.sv
// Single-outstanding arbiter sharing one AHB memory adapter among NUM_REQS requesters.
// Define VX_MEM_ARB_RR_EN for round-robin; otherwise fixed priority (lowest index wins).
module vx_mem_arbiter
    import vx_mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQS     = DEF_NUM_REQS,
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int unsigned TAG_WIDTH    = DEF_TAG_WIDTH,
    parameter int unsigned BYTEEN_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned IDX_WIDTH    = (NUM_REQS > 2) ? $clog2(NUM_REQS) : 1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_REQS-1:0]                     up_req_valid,
    input  logic [NUM_REQS-1:0]                     up_req_rw,
    input  logic [NUM_REQS-1:0][ADDR_WIDTH-1:0]     up_req_addr,
    input  logic [NUM_REQS-1:0][DATA_WIDTH-1:0]     up_req_data,
    input  logic [NUM_REQS-1:0][BYTEEN_WIDTH-1:0]   up_req_byteen,
    input  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]      up_req_tag,
    output logic [NUM_REQS-1:0]                     up_req_ready,
    output logic [NUM_REQS-1:0]                     up_rsp_valid,
    output logic [DATA_WIDTH-1:0]                   up_rsp_data,
    output logic [TAG_WIDTH-1:0]                    up_rsp_tag,
    input  logic [NUM_REQS-1:0]                     up_rsp_ready,
    output logic                                    dn_req_valid,
    output logic                                    dn_req_rw,
    output logic [ADDR_WIDTH-1:0]                   dn_req_addr,
    output logic [DATA_WIDTH-1:0]                   dn_req_data,
    output logic [BYTEEN_WIDTH-1:0]                 dn_req_byteen,
    output logic [TAG_WIDTH-1:0]                    dn_req_tag,
    input  logic                                    dn_req_ready,
    input  logic                                    dn_rsp_valid,
    input  logic [DATA_WIDTH-1:0]                   dn_rsp_data,
    input  logic [TAG_WIDTH-1:0]                    dn_rsp_tag,
    output logic                                    dn_rsp_ready,
    output logic                                    busy,
    output logic [IDX_WIDTH-1:0]                    grant_idx
);

    arb_state_e           r_state;
    arb_state_e           w_state_nxt;
    logic [IDX_WIDTH-1:0] r_grant_idx;
    logic [IDX_WIDTH-1:0] w_grant_nxt;
    logic [IDX_WIDTH-1:0] w_ptr;
    logic [IDX_WIDTH-1:0] w_pick_idx;
    logic                 w_pick_any;
    logic                 w_req_fire;
    logic                 w_rsp_fire;

    assign w_req_fire = up_req_valid[r_grant_idx] & dn_req_ready;
    assign w_rsp_fire = dn_rsp_valid & up_rsp_ready[r_grant_idx];

    vx_rr_picker #(
        .NUM_REQS  (NUM_REQS),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_picker (
        .i_valid (up_req_valid),
        .i_ptr   (w_ptr),
        .o_idx_c (w_pick_idx),
        .o_any_c (w_pick_any)
    );

`ifdef VX_MEM_ARB_RR_EN
    logic [IDX_WIDTH-1:0] r_ptr;

    // Pointer advances past the requester whose response just completed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (r_state == WAIT_RSP && w_rsp_fire) begin
            r_ptr <= (r_grant_idx == IDX_WIDTH'(NUM_REQS - 1)) ? '0 : r_grant_idx + IDX_WIDTH'(1);
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_grant_idx <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant_idx <= w_grant_nxt;
        end
    end

    // Next state plus state-gated channel muxing; everything idles at zero.
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant_idx;
        up_req_ready  = '0;
        up_rsp_valid  = '0;
        up_rsp_data   = '0;
        up_rsp_tag    = '0;
        dn_req_valid  = 1'b0;
        dn_req_rw     = 1'b0;
        dn_req_addr   = '0;
        dn_req_data   = '0;
        dn_req_byteen = '0;
        dn_req_tag    = '0;
        dn_rsp_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt = ISSUE;
                    w_grant_nxt = w_pick_idx;
                end
            end
            ISSUE: begin
                dn_req_valid               = up_req_valid[r_grant_idx];
                dn_req_rw                  = up_req_rw[r_grant_idx];
                dn_req_addr                = up_req_addr[r_grant_idx];
                dn_req_data                = up_req_data[r_grant_idx];
                dn_req_byteen              = up_req_byteen[r_grant_idx];
                dn_req_tag                 = up_req_tag[r_grant_idx];
                up_req_ready[r_grant_idx]  = dn_req_ready;
                if (w_req_fire) begin
                    w_state_nxt = WAIT_RSP;
                end else if (!up_req_valid[r_grant_idx]) begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT_RSP: begin
                up_rsp_valid[r_grant_idx] = dn_rsp_valid;
                dn_rsp_ready              = up_rsp_ready[r_grant_idx];
                up_rsp_data               = dn_rsp_data;
                up_rsp_tag                = dn_rsp_tag;
                if (w_rsp_fire) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign busy      = (r_state != IDLE);
    assign grant_idx = r_grant_idx;

endmodule

// File: tb/tb_vx_mem_arbiter.sv
// Self-checking bench for vx_mem_arbiter: directed scenarios plus randomized traffic vs a transaction-level model.
module tb_vx_mem_arbiter;

    localparam int N  = 3;
    localparam int DW = 512;
    localparam int AW = 26;
    localparam int TW = 8;
    localparam int BW = 64;
    localparam int IW = 2;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [N-1:0]           up_req_valid, up_req_rw, up_req_ready, up_rsp_valid, up_rsp_ready;
    logic [N-1:0][AW-1:0]   up_req_addr;
    logic [N-1:0][DW-1:0]   up_req_data;
    logic [N-1:0][BW-1:0]   up_req_byteen;
    logic [N-1:0][TW-1:0]   up_req_tag;
    logic [DW-1:0]          up_rsp_data, dn_req_data, dn_rsp_data;
    logic [TW-1:0]          up_rsp_tag, dn_req_tag, dn_rsp_tag;
    logic                   dn_req_valid, dn_req_rw, dn_req_ready, dn_rsp_valid, dn_rsp_ready, busy;
    logic [AW-1:0]          dn_req_addr;
    logic [BW-1:0]          dn_req_byteen;
    logic [IW-1:0]          grant_idx;

    vx_mem_arbiter #(.NUM_REQS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW),
                     .BYTEEN_WIDTH(BW), .IDX_WIDTH(IW)) dut (
        .clk(clk), .reset(reset),
        .up_req_valid(up_req_valid), .up_req_rw(up_req_rw), .up_req_addr(up_req_addr),
        .up_req_data(up_req_data), .up_req_byteen(up_req_byteen), .up_req_tag(up_req_tag),
        .up_req_ready(up_req_ready), .up_rsp_valid(up_rsp_valid), .up_rsp_data(up_rsp_data),
        .up_rsp_tag(up_rsp_tag), .up_rsp_ready(up_rsp_ready),
        .dn_req_valid(dn_req_valid), .dn_req_rw(dn_req_rw), .dn_req_addr(dn_req_addr),
        .dn_req_data(dn_req_data), .dn_req_byteen(dn_req_byteen), .dn_req_tag(dn_req_tag),
        .dn_req_ready(dn_req_ready), .dn_rsp_valid(dn_rsp_valid), .dn_rsp_data(dn_rsp_data),
        .dn_rsp_tag(dn_rsp_tag), .dn_rsp_ready(dn_rsp_ready),
        .busy(busy), .grant_idx(grant_idx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Transaction-level reference: who owns the adapter, whether its request was taken, RR pointer.
    int m_owner = -1;
    bit m_acc   = 1'b0;
    int m_ptr   = 0;
    int m_grant = 0;
    int grants[$];

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_wide();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            int p;
            p = (ptr + k) % N;
            if (v[p]) return p;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_acc   = 1'b0;
        m_ptr   = 0;
        m_grant = 0;
    endtask

    task automatic clear_inputs();
        up_req_valid = '0; up_req_rw = '0; up_req_addr = '0; up_req_data = '0;
        up_req_byteen = '0; up_req_tag = '0; up_rsp_ready = '0;
        dn_req_ready = 1'b0; dn_rsp_valid = 1'b0; dn_rsp_data = '0; dn_rsp_tag = '0;
    endtask

    task automatic set_req(input int i, input logic rw, input logic [AW-1:0] a,
                           input logic [TW-1:0] t, input logic [BW-1:0] be);
        up_req_valid[i]  = 1'b1;
        up_req_rw[i]     = rw;
        up_req_addr[i]   = a;
        up_req_data[i]   = rand_wide();
        up_req_byteen[i] = be;
        up_req_tag[i]    = t;
    endtask

    // Compare every output against what the model says at this point in the transaction.
    task automatic check_cycle();
        logic [N-1:0]  e_rdy, e_rv;
        logic          e_dv, e_rw, e_drr;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data, e_rdata;
        logic [BW-1:0] e_be;
        logic [TW-1:0] e_tag, e_rtag;
        @(negedge clk);
        e_rdy = '0; e_rv = '0; e_dv = 1'b0; e_rw = 1'b0; e_drr = 1'b0;
        e_addr = '0; e_data = '0; e_rdata = '0; e_be = '0; e_tag = '0; e_rtag = '0;
        if (m_owner >= 0 && !m_acc) begin
            e_dv   = up_req_valid[m_owner];
            e_rw   = up_req_rw[m_owner];
            e_addr = up_req_addr[m_owner];
            e_data = up_req_data[m_owner];
            e_be   = up_req_byteen[m_owner];
            e_tag  = up_req_tag[m_owner];
            e_rdy[m_owner] = dn_req_ready;
        end else if (m_owner >= 0) begin
            e_rv[m_owner] = dn_rsp_valid;
            e_drr   = up_rsp_ready[m_owner];
            e_rdata = dn_rsp_data;
            e_rtag  = dn_rsp_tag;
        end
        chk("busy",          DW'(busy),          DW'(m_owner >= 0));
        chk("grant_idx",     DW'(grant_idx),     DW'(m_grant));
        chk("dn_req_valid",  DW'(dn_req_valid),  DW'(e_dv));
        chk("dn_req_rw",     DW'(dn_req_rw),     DW'(e_rw));
        chk("dn_req_addr",   DW'(dn_req_addr),   DW'(e_addr));
        chk("dn_req_data",   dn_req_data,        e_data);
        chk("dn_req_byteen", DW'(dn_req_byteen), DW'(e_be));
        chk("dn_req_tag",    DW'(dn_req_tag),    DW'(e_tag));
        chk("up_req_ready",  DW'(up_req_ready),  DW'(e_rdy));
        chk("up_rsp_valid",  DW'(up_rsp_valid),  DW'(e_rv));
        chk("dn_rsp_ready",  DW'(dn_rsp_ready),  DW'(e_drr));
        chk("up_rsp_data",   up_rsp_data,        e_rdata);
        chk("up_rsp_tag",    DW'(up_rsp_tag),    DW'(e_rtag));
    endtask

    // Apply the handshake rules for the coming edge, then move to just after it.
    task automatic advance();
        if (reset) begin
            if (m_owner < 0) begin
                int w;
                w = pick(up_req_valid, m_ptr);
                if (w >= 0) begin
                    m_owner = w;
                    m_grant = w;
                end
            end else if (!m_acc) begin
                if (up_req_valid[m_owner] && dn_req_ready) begin
                    m_acc = 1'b1;
                    grants.push_back(m_owner);
                end else if (!up_req_valid[m_owner]) begin
                    m_owner = -1;
                end
            end else if (dn_rsp_valid && up_rsp_ready[m_owner]) begin
`ifdef VX_MEM_ARB_RR_EN
                m_ptr = (m_owner + 1) % N;
`endif
                m_owner = -1;
                m_acc   = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        check_cycle();
        advance();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_order[4];
        reset = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) step();
        reset = 1'b1;
        step();

        // Single read from requester 1.
        set_req(1, 1'b0, 26'h0001234, 8'h5A, '1);
        dn_req_ready = 1'b1;
        step();
        check_cycle();
        chk("t1_dn_valid", DW'(dn_req_valid), DW'(1));
        chk("t1_dn_addr",  DW'(dn_req_addr),  DW'(26'h0001234));
        chk("t1_up_ready", DW'(up_req_ready), DW'(3'b010));
        advance();
        up_req_valid = '0;
        dn_rsp_valid = 1'b1; dn_rsp_data = rand_wide(); dn_rsp_tag = 8'h5A; up_rsp_ready = '1;
        check_cycle();
        chk("t1_rsp_valid", DW'(up_rsp_valid), DW'(3'b010));
        chk("t1_rsp_tag",   DW'(up_rsp_tag),   DW'(8'h5A));
        advance();
        dn_rsp_valid = 1'b0;
        check_cycle();
        chk("t1_back_idle", DW'(busy), DW'(0));
        advance();

        // Contention between requesters 0 and 1.
        up_req_valid = 3'b011; dn_req_ready = 1'b1; dn_rsp_valid = 1'b1; up_rsp_ready = '1;
        grants.delete();
        for (int c = 0; c < 40 && grants.size() < 4; c++) step();
        if (grants.size() < 4) chk("t2_timeout", DW'(grants.size()), DW'(4));
`ifdef VX_MEM_ARB_RR_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        for (int i = 0; i < 4 && i < grants.size(); i++)
            chk($sformatf("t2_order%0d", i), DW'(grants[i]), DW'(exp_order[i]));
        up_req_valid = '0;
        repeat (3) step();
        clear_inputs();
        step();

        // Write from requester 0.
        set_req(0, 1'b1, 26'h2ABCDEF, 8'h11, 64'hFFFF_0000_0000_00FF);
        dn_req_ready = 1'b1;
        step();
        check_cycle();
        chk("t3_rw",     DW'(dn_req_rw),     DW'(1));
        chk("t3_byteen", DW'(dn_req_byteen), DW'(64'hFFFF_0000_0000_00FF));
        advance();
        up_req_valid = '0; dn_rsp_valid = 1'b1; up_rsp_ready = '1;
        step();
        check_cycle();
        chk("t3_idle", DW'(busy), DW'(0));
        advance();
        clear_inputs();

        // Response backpressure on requester 0 while requester 1 waits.
        set_req(0, 1'b0, 26'h0000042, 8'h21, '1);
        dn_req_ready = 1'b1;
        step();
        step();
        set_req(1, 1'b0, 26'h0000043, 8'h22, '1);
        dn_rsp_valid = 1'b1; dn_rsp_data = rand_wide(); up_rsp_ready = 3'b110;
        up_req_valid[0] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check_cycle();
            chk("t4_dn_rsp_ready", DW'(dn_rsp_ready), DW'(0));
            chk("t4_busy",         DW'(busy),         DW'(1));
            chk("t4_grant",        DW'(grant_idx),    DW'(0));
            chk("t4_no_req_ready", DW'(up_req_ready), DW'(0));
            advance();
        end
        up_rsp_ready = '1;
        step();
        dn_rsp_valid = 1'b0;
        step();
        up_req_valid = '0;
        repeat (3) step();
        clear_inputs();

        // Asynchronous reset while waiting on requester 2's response.
        set_req(2, 1'b0, 26'h0000777, 8'h33, '1);
        dn_req_ready = 1'b1;
        step();
        step();
        up_req_valid = '0; dn_rsp_valid = 1'b1; up_rsp_ready = '1;
        #1;
        chk("t5_pre_rsp_valid", DW'(up_rsp_valid), DW'(3'b100));
        reset = 1'b0;
        #1;
        model_reset();
        chk("t5_busy",         DW'(busy),         DW'(0));
        chk("t5_grant",        DW'(grant_idx),    DW'(0));
        chk("t5_rsp_valid",    DW'(up_rsp_valid), DW'(0));
        chk("t5_dn_rsp_ready", DW'(dn_rsp_ready), DW'(0));
        chk("t5_dn_req_valid", DW'(dn_req_valid), DW'(0));
        step();
        reset = 1'b1;
        dn_rsp_valid = 1'b0;
        set_req(1, 1'b0, 26'h0000888, 8'h44, '1);
        step();
        check_cycle();
        chk("t5_regrant", DW'(grant_idx), DW'(1));
        chk("t5_dn_valid", DW'(dn_req_valid), DW'(1));
        advance();
        up_req_valid = '0; dn_rsp_valid = 1'b1;
        repeat (2) step();
        clear_inputs();

        // Pointer wrap: requester 2 completes, then 0 and 2 contend.
        set_req(2, 1'b0, 26'h0000999, 8'h55, '1);
        dn_req_ready = 1'b1;
        step();
        step();
        up_req_valid = '0; dn_rsp_valid = 1'b1; up_rsp_ready = '1;
        step();
        dn_rsp_valid = 1'b0;
        set_req(0, 1'b0, 26'h0000AAA, 8'h66, '1);
        set_req(2, 1'b0, 26'h0000BBB, 8'h77, '1);
        step();
        check_cycle();
        chk("t6_wrap_grant", DW'(grant_idx), DW'(0));
        advance();
        clear_inputs();
        repeat (3) step();

        // Randomized traffic, including rare asynchronous reset pulses.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                up_req_valid[i]  = ($urandom_range(0, 3) != 0);
                up_req_rw[i]     = 1'($urandom);
                up_req_addr[i]   = AW'($urandom);
                up_req_data[i]   = rand_wide();
                up_req_byteen[i] = {$urandom, $urandom};
                up_req_tag[i]    = TW'($urandom);
            end
            up_rsp_ready = N'($urandom);
            dn_req_ready = 1'($urandom);
            dn_rsp_valid = ($urandom_range(0, 2) != 0);
            dn_rsp_data  = rand_wide();
            dn_rsp_tag   = TW'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b0;
                #1;
                model_reset();
                reset = 1'b1;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vx_mem_arbiter.md
# vx_mem_arbiter

- Shares the single-outstanding AHB memory adapter among `NUM_REQS` Vortex memory requesters (e.g. I-cache, D-cache, DMA).
- Sits between requester-side mem request/response channels and the adapter's request/response channels.
- Arbitrates one transaction at a time: a grant is held from request acceptance until the matching response handshake, and the response is routed back to the granted requester.

## Interface
Parameters:
- NUM_REQS, 2, number of upstream requesters (2..8)
- DATA_WIDTH, 512, request/response data width
- ADDR_WIDTH, 26, line address width (32 - log2(DATA_WIDTH/8))
- TAG_WIDTH, 8, tag width, passed through unchanged
- BYTEEN_WIDTH, DATA_WIDTH/8, byte-enable width
- IDX_WIDTH, max(1, $clog2(NUM_REQS)), requester index width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- up_req_valid  in  NUM_REQS  per-requester request valid
- up_req_rw  in  NUM_REQS  1 = write
- up_req_addr  in  NUM_REQS x ADDR_WIDTH  line address
- up_req_data  in  NUM_REQS x DATA_WIDTH  write data
- up_req_byteen  in  NUM_REQS x BYTEEN_WIDTH  byte enables
- up_req_tag  in  NUM_REQS x TAG_WIDTH  request tag
- up_req_ready  out  NUM_REQS  request accepted, one-hot or zero
- up_rsp_valid  out  NUM_REQS  response valid, one-hot or zero
- up_rsp_data  out  DATA_WIDTH  response data, shared by all requesters
- up_rsp_tag  out  TAG_WIDTH  response tag, shared by all requesters
- up_rsp_ready  in  NUM_REQS  per-requester response ready
- dn_req_valid, dn_req_rw, dn_req_addr, dn_req_data, dn_req_byteen, dn_req_tag  out  1/1/ADDR/DATA/BYTEEN/TAG  request to the adapter
- dn_req_ready  in  1  adapter request ready
- dn_rsp_valid  in  1  adapter response valid
- dn_rsp_data  in  DATA_WIDTH  adapter response data
- dn_rsp_tag  in  TAG_WIDTH  adapter response tag
- dn_rsp_ready  out  1  response ready to the adapter
- busy  out  1  high whenever the state is not IDLE
- grant_idx  out  IDX_WIDTH  registered index of the current grant

## Operation
- States: IDLE, ISSUE, WAIT_RSP.
- IDLE:
  - If any up_req_valid is set, the picker selects a winner; grant_idx is registered and the next state is ISSUE.
  - Otherwise the block stays in IDLE.
- ISSUE:
  - dn_req_* carries the granted requester's fields.
  - dn_req_valid = up_req_valid[grant_idx].
  - up_req_ready[grant_idx] = dn_req_ready; all other up_req_ready bits are 0.
  - On the handshake (valid & ready), the next state is WAIT_RSP.
  - If the granted requester drops valid before the handshake (protocol violation), return to IDLE with no pointer update.
- WAIT_RSP:
  - up_rsp_valid[grant_idx] = dn_rsp_valid.
  - dn_rsp_ready = up_rsp_ready[grant_idx].
  - up_rsp_data and up_rsp_tag pass straight through from the adapter.
  - On the response handshake, the next state is IDLE and the priority pointer updates.
- Every request receives exactly one response, reads and writes alike. The downstream is required to return a response for each request.
- Tags are not modified. Routing uses the registered grant_idx only.
- Outside their active state, all dn_* and up_* outputs are 0, including data buses.

## Timing
- Reset values: state IDLE, grant_idx 0, pointer 0, busy 0, all valid/ready outputs 0, all data/tag outputs 0.
- Request path:
  - Cycle 0: up_req_valid is sampled in IDLE.
  - Cycle 1: dn_req_valid is high.
  - If dn_req_ready is high in cycle 1, up_req_ready is high in cycle 1.
- Response path: combinational pass-through with zero added latency.
- Minimum turnaround: one IDLE cycle between consecutive transactions, for a minimum of 3 cycles per transaction plus adapter latency.
- Simultaneous requests: exactly one grant per arbitration. The other requesters hold valid and wait.
- Asynchronous reset mid-transaction returns the block to IDLE immediately and drops the in-flight grant. Responses in flight are discarded (dn_rsp_ready = 0).

## Configuration
- VX_MEM_ARB_RR_EN defined:
  - Round-robin arbitration.
  - The search starts at pointer; after each response handshake, pointer = grant_idx + 1, wrapping to 0 after NUM_REQS-1.
- Undefined:
  - Fixed priority: the lowest index wins.
  - The pointer register is removed and held at 0.

## Structure
- Package vx_mem_arb_pkg holds:
  - the state enum arb_state_e (IDLE, ISSUE, WAIT_RSP);
  - localparams for the default widths.
- Sub-module vx_rr_picker:
  - combinational rotate / priority-encode of the valid vector starting from the pointer;
  - outputs the winner index and an any-valid flag.

## Test plan
- Single request: requester 1 read, addr 26'h0001234, tag 8'h5A, adapter ready in cycle 1 -> dn_req_addr 26'h0001234 in cycle 1, up_req_ready[1] high in cycle 1, response data is delivered only to up_rsp_valid[1] with tag 8'h5A.
- Contention, RR enabled, NUM_REQS=2: both requesters hold valid for 4 transactions -> grant order 0,1,0,1. Same stimulus with RR disabled -> 0,0,0,0.
- Write routing: requester 0 write with byteen 64'hFFFF_0000_0000_00FF -> dn_req_rw 1 and dn_req_byteen equal to the input; the response handshake returns the block to IDLE.
- Response backpressure: up_rsp_ready[0] held low for 5 cycles -> dn_rsp_ready low, state stays WAIT_RSP, no new grant to requester 1.
- Reset mid-WAIT_RSP: reset asserted -> busy 0, grant_idx 0, all valid outputs 0 asynchronously. After release, a fresh request is granted normally.
- Wrap-around, NUM_REQS=3, RR enabled: grant to 2 completes, then requesters 0 and 2 are both valid -> requester 0 is granted.
